timer_btn_ctrl: RTL and testbench

Front-panel controller for the timer/counter. It takes the debounced, clock-synchronous levels of the three panel buttons (start, mode, inc) and runs the timer mode state machine. It issues run/clear/increment commands to the counter datapath. Long-press and auto-repeat timing are counted in `tick` strobes from the timebase, not in clocks.

---
 rtl/timer_btn_ctrl.sv | 157 +++++++++++++++
 tb/tb_timer_btn_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/timer_btn_ctrl.sv
// Front-panel button controller for the timer/counter: edge detection, long-press
// and auto-repeat timing in tick units, and the IDLE/RUN/PAUSE/SET_MIN/SET_SEC mode FSM.
module timer_btn_ctrl #(
  parameter int LONG_TICKS   = 8,
  parameter int REPEAT_TICKS = 3,
  parameter int HOLD_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run,
  output logic       clr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    SET_MIN = 3'd3,
    SET_SEC = 3'd4
  } state_t;

  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] LONG_M1  = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_M1   = HOLD_W'(REPEAT_TICKS - 1);

  state_t            st;
  logic              start_q, mode_q, inc_q;
  logic              armed;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] rep_cnt;
  logic              start_rise, mode_rise, inc_rise;

  assign start_rise = btn_start & ~start_q;
  assign mode_rise  = btn_mode  & ~mode_q;
  assign inc_rise   = btn_inc   & ~inc_q;
  assign state      = st;

  // armed marks a press that began in the current state; a button carried
  // over from a previous state (or from reset) never owns the hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      run      <= 1'b0;
      clr      <= 1'b0;
      inc_min  <= 1'b0;
      inc_sec  <= 1'b0;
      start_q  <= 1'b1;
      mode_q   <= 1'b1;
      inc_q    <= 1'b1;
      armed    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      start_q <= btn_start;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      clr     <= 1'b0;
      inc_min <= 1'b0;
      inc_sec <= 1'b0;
      case (st)
        IDLE: begin
          armed    <= 1'b0;
          hold_cnt <= '0;
          rep_cnt  <= '0;
          if (start_rise) begin
            st  <= RUN;
            run <= 1'b1;
          end else if (mode_rise) begin
            st <= SET_MIN;
          end
        end
        RUN: begin
          armed    <= 1'b0;
          hold_cnt <= '0;
          rep_cnt  <= '0;
          if (start_rise) begin
            st  <= PAUSE;
            run <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_rise) begin
            armed    <= 1'b1;
            hold_cnt <= '0;
          end else if (armed) begin
            if (!btn_start) begin
              st       <= RUN;
              run      <= 1'b1;
              armed    <= 1'b0;
              hold_cnt <= '0;
            end else if (tick) begin
              if (hold_cnt == LONG_M1) begin
                st       <= IDLE;
                clr      <= 1'b1;
                armed    <= 1'b0;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
        end
        SET_MIN, SET_SEC: begin
          if (mode_rise) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            if (st == SET_MIN) begin
              st <= SET_SEC;
            end else begin
              st  <= IDLE;
              clr <= 1'b1;
            end
          end else if (inc_rise) begin
            armed    <= 1'b1;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            inc_min  <= (st == SET_MIN);
            inc_sec  <= (st == SET_SEC);
          end else if (armed) begin
            if (!btn_inc) begin
              armed    <= 1'b0;
              hold_cnt <= '0;
              rep_cnt  <= '0;
            end else if (tick) begin
              if (hold_cnt != LONG_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == LONG_M1) begin
                  inc_min <= (st == SET_MIN);
                  inc_sec <= (st == SET_SEC);
                end
              end else if (rep_cnt == REP_M1) begin
                rep_cnt <= '0;
                inc_min <= (st == SET_MIN);
                inc_sec <= (st == SET_SEC);
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          st  <= IDLE;
          run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_btn_ctrl.sv
// Directed bench for timer_btn_ctrl with LONG_TICKS=4, REPEAT_TICKS=2.
module tb_timer_btn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       run, clr, inc_min, inc_sec;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  timer_btn_ctrl #(.LONG_TICKS(4), .REPEAT_TICKS(2), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .run(run), .clr(clr), .inc_min(inc_min), .inc_sec(inc_sec), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s, m, i, t;
    logic [2:0] st;
    logic       run, clr, imin, isec;
  } vec_t;

  function automatic vec_t mkv(logic s, logic m, logic i, logic t, logic [2:0] st,
                               logic r, logic c, logic im, logic is);
    vec_t v;
    v.s = s; v.m = m; v.i = i; v.t = t; v.st = st;
    v.run = r; v.clr = c; v.imin = im; v.isec = is;
    return v;
  endfunction

  task automatic cyc(input logic s, input logic m, input logic i, input logic t);
    @(negedge clk);
    btn_start = s; btn_mode = m; btn_inc = i; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic r,
                     input logic c, input logic im, input logic is);
    checks++;
    if ({state, run, clr, inc_min, inc_sec} !== {st, r, c, im, is}) begin
      errors++;
      $display("FAIL %s: got st=%0d run=%b clr=%b imin=%b isec=%b, expected st=%0d run=%b clr=%b imin=%b isec=%b",
               nm, state, run, clr, inc_min, inc_sec, st, r, c, im, is);
    end
  endtask

  vec_t tbl[23];

  initial begin
    int n;
    int np;
    logic tk;
    logic exp_p;

    // IDLE/RUN/PAUSE walk starting from IDLE with all buttons low
    tbl[0]  = mkv(1,0,0,0, 3'd1, 1,0,0,0);
    tbl[1]  = mkv(0,0,0,0, 3'd1, 1,0,0,0);
    tbl[2]  = mkv(0,1,0,0, 3'd1, 1,0,0,0);
    tbl[3]  = mkv(0,0,1,0, 3'd1, 1,0,0,0);
    tbl[4]  = mkv(0,0,0,0, 3'd1, 1,0,0,0);
    tbl[5]  = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[6]  = mkv(0,0,0,0, 3'd2, 0,0,0,0);
    tbl[7]  = mkv(0,1,0,0, 3'd2, 0,0,0,0);
    tbl[8]  = mkv(0,0,0,0, 3'd2, 0,0,0,0);
    tbl[9]  = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[10] = mkv(1,0,0,1, 3'd2, 0,0,0,0);
    tbl[11] = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[12] = mkv(1,0,0,1, 3'd2, 0,0,0,0);
    tbl[13] = mkv(0,0,0,0, 3'd1, 1,0,0,0);
    tbl[14] = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[15] = mkv(0,0,0,0, 3'd2, 0,0,0,0);
    tbl[16] = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[17] = mkv(1,0,0,1, 3'd2, 0,0,0,0);
    tbl[18] = mkv(1,0,0,1, 3'd2, 0,0,0,0);
    tbl[19] = mkv(1,0,0,1, 3'd2, 0,0,0,0);
    tbl[20] = mkv(0,0,0,1, 3'd1, 1,0,0,0);
    tbl[21] = mkv(1,0,0,0, 3'd2, 0,0,0,0);
    tbl[22] = mkv(0,0,0,0, 3'd2, 0,0,0,0);

    // reset with start held
    btn_start = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("in_reset", 3'd0, 0,0,0,0);
    @(negedge clk) rst = 1'b1;
    cyc(1,0,0,0); chk("held_after_rst0", 3'd0, 0,0,0,0);
    cyc(1,0,0,1); chk("held_after_rst1", 3'd0, 0,0,0,0);
    cyc(0,0,0,0); chk("release_after_rst", 3'd0, 0,0,0,0);

    for (int k = 0; k < 23; k++) begin
      cyc(tbl[k].s, tbl[k].m, tbl[k].i, tbl[k].t);
      chk($sformatf("vec%0d", k), tbl[k].st, tbl[k].run, tbl[k].clr, tbl[k].imin, tbl[k].isec);
    end

    // long press in PAUSE: hold start for 6 ticks, clr at the 4th
    n = 0;
    for (int c = 0; c < 30; c++) begin
      tk = (c % 5 == 4);
      if (tk) n++;
      cyc(1,0,0,tk);
      chk($sformatf("long_c%0d", c), (n >= 4) ? 3'd0 : 3'd2, 0, tk && n == 4, 0, 0);
    end
    cyc(0,0,0,0); chk("long_release", 3'd0, 0,0,0,0);
    cyc(0,0,0,1); chk("long_release2", 3'd0, 0,0,0,0);

    // auto-repeat in SET_MIN over 9 ticks
    cyc(0,1,0,0); chk("to_set_min", 3'd3, 0,0,0,0);
    cyc(0,0,0,0); chk("set_min_idle", 3'd3, 0,0,0,0);
    n = 0; np = 0;
    for (int c = 0; c < 45; c++) begin
      tk = (c % 5 == 4);
      if (tk) n++;
      exp_p = (c == 0) || (tk && (n == 4 || n == 6 || n == 8));
      cyc(0,0,1,tk);
      if (inc_min) np++;
      chk($sformatf("rep_c%0d", c), 3'd3, 0,0, exp_p, 0);
    end
    checks++;
    if (np != 4) begin
      errors++;
      $display("FAIL rep_count: got %0d inc_min pulses, expected 4", np);
    end
    for (int c = 0; c < 12; c++) begin
      cyc(0,0,0, c % 5 == 4);
      chk($sformatf("rep_rel_c%0d", c), 3'd3, 0,0,0,0);
    end

    // SET_SEC increment, then mode+inc on the same edge
    cyc(0,1,0,0); chk("to_set_sec", 3'd4, 0,0,0,0);
    cyc(0,0,0,0); chk("set_sec_idle", 3'd4, 0,0,0,0);
    cyc(0,0,1,0); chk("inc_sec_rise", 3'd4, 0,0,0,1);
    cyc(0,0,0,0); chk("inc_sec_rel", 3'd4, 0,0,0,0);
    cyc(0,1,1,0); chk("mode_inc_same", 3'd0, 0,1,0,0);
    cyc(0,0,0,0); chk("idle_after_sec", 3'd0, 0,0,0,0);
    cyc(1,1,0,0); chk("start_mode_same", 3'd1, 1,0,0,0);
    cyc(0,0,0,0); chk("run_hold", 3'd1, 1,0,0,0);

    // reset mid-press with inc still held
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_from_run", 3'd0, 0,0,0,0);
    @(negedge clk) rst = 1'b1;
    cyc(0,1,0,0); chk("to_set_min2", 3'd3, 0,0,0,0);
    cyc(0,0,0,0); chk("set_min2_idle", 3'd3, 0,0,0,0);
    for (int c = 0; c < 15; c++) begin
      cyc(0,0,1, c % 5 == 4);
      chk($sformatf("pre_rst_c%0d", c), 3'd3, 0,0, c == 0, 0);
    end
    #2 rst = 1'b0;
    #1 chk("rst_mid_press", 3'd0, 0,0,0,0);
    for (int c = 0; c < 3; c++) begin
      cyc(0,0,1, c == 1);
      chk($sformatf("during_rst_c%0d", c), 3'd0, 0,0,0,0);
    end
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      cyc(0,0,1, c % 5 == 4);
      chk($sformatf("post_rst_c%0d", c), 3'd0, 0,0,0,0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
